l2_line_server: RTL and testbench

- L2-side responder for the 32-byte-line request/done handshake that L1 prefetch and fill initiators drive (l2_request/l2_addr in; l2_data/l2_done out).
- Holds a small direct-mapped line store. Hits are answered after a fixed latency.
- Misses fetch the line from memory as four 64-bit beats, fill the store, then respond.
- Sits between the prefetch/fill initiators and the memory port.

---
 rtl/l2_line_server_if.sv | 23 ++
 rtl/l2_line_server.sv | 168 ++++++++++++++++
 tb/tb_l2_line_server.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/l2_line_server_if.sv
// Request/done handshake from the L1 initiators plus the memory read port.
// master = initiator + memory side, slave = l2_line_server.
interface l2_line_server_if;
    logic         l2_request;
    logic [31:0]  l2_addr;
    logic [255:0] l2_data;
    logic         l2_done;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;

    modport master (
        output l2_request, l2_addr, mem_ack, mem_rvalid, mem_rdata,
        input  l2_data, l2_done, mem_req, mem_addr
    );

    modport slave (
        input  l2_request, l2_addr, mem_ack, mem_rvalid, mem_rdata,
        output l2_data, l2_done, mem_req, mem_addr
    );
endinterface

// File: rtl/l2_line_server.sv
// Direct-mapped 32-byte line store answering L1 line requests.
// Hits respond after HIT_LATENCY cycles; misses refill from memory in four 64-bit beats.
module l2_line_server #(
    parameter int LINES       = 8,
    parameter int HIT_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    l2_line_server_if.slave    bus,
    input  logic               flush,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 27 - IDX;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, HIT_WAIT, MEM_REQ, MEM_DATA, RESPOND, RELEASE
    } state_t;

    state_t             state_reg;
    logic [26:0]        line_addr_reg;
    logic [LINES-1:0]   valid_reg;
    logic               flush_pend_reg;
    logic [3:0]         wait_cnt_reg;
    logic [1:0]         beat_reg;
    logic               l2_done_reg;
    logic [255:0]       l2_data_reg;
    logic               mem_req_reg;
    logic [31:0]        mem_addr_reg;
    logic [15:0]        hit_count_reg;
    logic [15:0]        miss_count_reg;

    logic [255:0]       line_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [63:0]        beat_buf [3];

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic               lookup_hit;
    logic               fill_we;
    logic [255:0]       fill_line;
    logic               unused_addr_bits;

    assign idx              = line_addr_reg[IDX-1:0];
    assign tag              = line_addr_reg[26:IDX];
    assign unused_addr_bits = ^bus.l2_addr[4:0];

    always_comb begin
        lookup_hit = valid_reg[idx] && (tag_mem[idx] == tag);
        fill_we    = (state_reg == MEM_DATA) && bus.mem_rvalid && (beat_reg == 2'd3);
        fill_line  = {bus.mem_rdata, beat_buf[2], beat_buf[1], beat_buf[0]};
    end

    // The first three beats park in lane registers; the fourth completes the line.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_beat_lane
            always_ff @(posedge clk) begin
                if (state_reg == MEM_DATA && bus.mem_rvalid && beat_reg == 2'(gi))
                    beat_buf[gi] <= bus.mem_rdata;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_we) begin
            line_mem[idx] <= fill_line;
            tag_mem[idx]  <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            line_addr_reg  <= '0;
            valid_reg      <= '0;
            flush_pend_reg <= 1'b0;
            wait_cnt_reg   <= '0;
            beat_reg       <= '0;
            l2_done_reg    <= 1'b0;
            l2_data_reg    <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            l2_done_reg <= 1'b0;
            if (flush && state_reg != IDLE)
                flush_pend_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (flush)
                        valid_reg <= '0;
                    if (bus.l2_request) begin
                        line_addr_reg <= bus.l2_addr[31:5];
                        state_reg     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        if (hit_count_reg != 16'hFFFF)
                            hit_count_reg <= hit_count_reg + 16'd1;
                        if (HIT_LATENCY == 1) begin
                            l2_done_reg <= 1'b1;
                            l2_data_reg <= line_mem[idx];
                            state_reg   <= RESPOND;
                        end else begin
                            wait_cnt_reg <= 4'd1;
                            state_reg    <= HIT_WAIT;
                        end
                    end else begin
                        if (miss_count_reg != 16'hFFFF)
                            miss_count_reg <= miss_count_reg + 16'd1;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= {line_addr_reg, 5'b0};
                        state_reg    <= MEM_REQ;
                    end
                end
                HIT_WAIT: begin
                    if (wait_cnt_reg == 4'(HIT_LATENCY - 1)) begin
                        l2_done_reg <= 1'b1;
                        l2_data_reg <= line_mem[idx];
                        state_reg   <= RESPOND;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req_reg <= 1'b0;
                        beat_reg    <= 2'd0;
                        state_reg   <= MEM_DATA;
                    end
                end
                MEM_DATA: begin
                    if (bus.mem_rvalid) begin
                        beat_reg <= beat_reg + 2'd1;
                        if (beat_reg == 2'd3) begin
                            valid_reg[idx] <= 1'b1;
                            l2_done_reg    <= 1'b1;
                            l2_data_reg    <= fill_line;
                            state_reg      <= RESPOND;
                        end
                    end
                end
                RESPOND: state_reg <= RELEASE;
                RELEASE: begin
                    // Pending flush lands on IDLE entry so a just-filled line is dropped too.
                    if (!bus.l2_request) begin
                        state_reg <= IDLE;
                        if (flush_pend_reg || flush)
                            valid_reg <= '0;
                        flush_pend_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.l2_done  = l2_done_reg;
    assign bus.l2_data  = l2_data_reg;
    assign bus.mem_req  = mem_req_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign hit_count    = hit_count_reg;
    assign miss_count   = miss_count_reg;
endmodule

// File: tb/tb_l2_line_server.sv
// Directed bench for l2_line_server: misses, hits, conflicts, handshake hold, flush and reset mid-fill.
module tb_l2_line_server;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int          n_cmp = 0;
    int          n_err = 0;

    l2_line_server_if bus ();

    l2_line_server #(.LINES(8), .HIT_LATENCY(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Done already seen: hold request 3 more cycles, then drop it and return to IDLE.
    task automatic release_txn(input logic [15:0] exp_hits, input logic [15:0] exp_misses);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_done_low", bus.l2_done, 1'b0);
            chk("hold_no_memreq", bus.mem_req, 1'b0);
        end
        chk("hold_hits", hit_count, exp_hits);
        chk("hold_misses", miss_count, exp_misses);
        bus.l2_request = 1'b0;
        tick;
        tick;
        $display("txn done: hits=%0d misses=%0d", hit_count, miss_count);
    endtask

    task automatic run_miss(input logic [31:0] a,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic [15:0] exp_hits, input logic [15:0] exp_misses,
                            input bit flush_mid, input bit junk_beat);
        logic [63:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        bus.l2_request = 1'b1;
        bus.l2_addr    = a;
        tick;
        tick;
        chk("miss_memreq", bus.mem_req, 1'b1);
        chk("miss_memaddr", bus.mem_addr, {a[31:5], 5'b0});
        chk("miss_count", miss_count, exp_misses);
        if (junk_beat) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            tick;
            bus.mem_rvalid = 1'b0;
            chk("memreq_held", bus.mem_req, 1'b1);
        end
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack = 1'b0;
        chk("memreq_dropped", bus.mem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beats[k];
            if (flush_mid && k == 1) flush = 1'b1;
            tick;
            flush = 1'b0;
            if (k < 3) chk("early_done", bus.l2_done, 1'b0);
        end
        bus.mem_rvalid = 1'b0;
        chk("miss_done", bus.l2_done, 1'b1);
        chk("miss_data", bus.l2_data, {b3, b2, b1, b0});
        release_txn(exp_hits, exp_misses);
    endtask

    task automatic run_hit(input logic [31:0] a, input logic [255:0] exp_line,
                           input logic [15:0] exp_hits, input logic [15:0] exp_misses);
        bus.l2_request = 1'b1;
        bus.l2_addr    = a;
        tick;
        tick;
        chk("hit_done_early", bus.l2_done, 1'b0);
        chk("hit_no_memreq", bus.mem_req, 1'b0);
        chk("hit_count", hit_count, exp_hits);
        tick;
        chk("hit_done", bus.l2_done, 1'b1);
        chk("hit_data", bus.l2_data, exp_line);
        release_txn(exp_hits, exp_misses);
    endtask

    initial begin
        reset_n        = 1'b0;
        flush          = 1'b0;
        bus.l2_request = 1'b0;
        bus.l2_addr    = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        tick;
        tick;
        reset_n = 1'b1;
        chk("rst_done", bus.l2_done, 1'b0);
        chk("rst_memreq", bus.mem_req, 1'b0);
        chk("rst_memaddr", bus.mem_addr, 32'h0);
        chk("rst_data", bus.l2_data, 256'h0);
        chk("rst_hits", hit_count, 16'd0);
        chk("rst_misses", miss_count, 16'd0);

        // Cold miss with a stray beat before ack, then a hit on the same line.
        run_miss(32'h0000_1040, 64'h1, 64'h2, 64'h3, 64'h4, 16'd0, 16'd1, 1'b0, 1'b1);
        run_hit(32'h0000_105C, {64'h4, 64'h3, 64'h2, 64'h1}, 16'd1, 16'd1);

        // Conflict eviction and re-fetch; flush raised mid-fill on the re-fetch.
        run_miss(32'h0000_1140, 64'h5, 64'h6, 64'h7, 64'h8, 16'd1, 16'd2, 1'b0, 1'b0);
        run_miss(32'h0000_1040, 64'h9, 64'hA, 64'hB, 64'hC, 16'd1, 16'd3, 1'b1, 1'b0);

        // Flushed line misses again; reset lands after beat 2.
        bus.l2_request = 1'b1;
        bus.l2_addr    = 32'h0000_1040;
        tick;
        tick;
        chk("postflush_memreq", bus.mem_req, 1'b1);
        chk("postflush_misses", miss_count, 16'd4);
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h11;
        tick;
        bus.mem_rdata  = 64'h12;
        tick;
        bus.mem_rdata  = 64'h13;
        reset_n        = 1'b0;
        bus.l2_request = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("midrst_memreq", bus.mem_req, 1'b0);
        chk("midrst_done", bus.l2_done, 1'b0);
        chk("midrst_hits", hit_count, 16'd0);
        chk("midrst_misses", miss_count, 16'd0);
        chk("midrst_data", bus.l2_data, 256'h0);
        bus.mem_rdata = 64'h14;
        tick;
        bus.mem_rvalid = 1'b0;
        tick;
        chk("late_beat_done", bus.l2_done, 1'b0);
        chk("late_beat_memreq", bus.mem_req, 1'b0);
        $display("reset mid-fill: hits=%0d misses=%0d", hit_count, miss_count);

        run_miss(32'h0000_1040, 64'h21, 64'h22, 64'h23, 64'h24, 16'd0, 16'd1, 1'b0, 1'b0);
        run_hit(32'h0000_1048, {64'h24, 64'h23, 64'h22, 64'h21}, 16'd1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
